// File: rtl/cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cbus_arbiter
// Description : Grants the shared cbus to one of NREQ requesters per burst and
//               routes response beats back to the owner; flags beat-count errors.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_arbiter #(
    parameter int NREQ = 2,
    parameter bit RR   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_is_write,
    input  logic [3*NREQ-1:0]    req_size,
    input  logic [64*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]    req_strobe,
    input  logic [64*NREQ-1:0]   req_data,
    input  logic [4*NREQ-1:0]    req_len,
    output logic [NREQ-1:0]      resp_ready,
    output logic [NREQ-1:0]      resp_last,
    output logic [63:0]          resp_data,
    output logic                 c_valid,
    output logic                 c_is_write,
    output logic [2:0]           c_size,
    output logic [63:0]          c_addr,
    output logic [7:0]           c_strobe,
    output logic [63:0]          c_data,
    output logic [3:0]           c_len,
    input  logic                 c_ready,
    input  logic                 c_last,
    input  logic [63:0]          c_data_in,
    output logic [NREQ-1:0]      grant,
    output logic                 len_err
);

    localparam int              IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] C_ONE = NREQ'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_win;
    logic [NREQ-1:0] r_grant;
    logic            r_is_write;
    logic [2:0]      r_size;
    logic [63:0]     r_addr;
    logic [7:0]      r_strobe;
    logic [3:0]      r_len;
    logic [3:0]      r_cnt;
    logic            r_len_err;
    logic            w_any;
    logic            w_beat;
    logic            w_done;

    logic            w_wr_a     [NREQ];
    logic [2:0]      w_size_a   [NREQ];
    logic [63:0]     w_addr_a   [NREQ];
    logic [7:0]      w_strobe_a [NREQ];
    logic [63:0]     w_data_a   [NREQ];
    logic [3:0]      w_len_a    [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_wr_a[gi]     = req_is_write[gi];
            assign w_size_a[gi]   = req_size[3*gi +: 3];
            assign w_addr_a[gi]   = req_addr[64*gi +: 64];
            assign w_strobe_a[gi] = req_strobe[8*gi +: 8];
            assign w_data_a[gi]   = req_data[64*gi +: 64];
            assign w_len_a[gi]    = req_len[4*gi +: 4];
        end
    endgenerate

    // First requester at or after the start index, wrapping; start is 0 unless RR.
    function automatic logic [IW-1:0] f_pick(input logic [NREQ-1:0] v,
                                             input logic [IW-1:0]   p);
        logic [IW-1:0] win;
        logic          found;
        logic [IW:0]   j;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = RR ? ({1'b0, p} + (IW+1)'(k)) : (IW+1)'(k);
            if (j >= (IW+1)'(NREQ)) begin
                j = j - (IW+1)'(NREQ);
            end
            if (!found && v[j[IW-1:0]]) begin
                found = 1'b1;
                win   = j[IW-1:0];
            end
        end
        return win;
    endfunction

    assign w_any   = |req_valid;
    assign w_win   = f_pick(req_valid, r_ptr);
    assign w_beat  = (r_state == S_BUSY) && c_ready;
    assign w_done  = w_beat && c_last;
    assign grant   = r_grant;
    assign len_err = r_len_err;

    always_comb begin
        w_state_nxt = r_state;
        c_valid     = 1'b0;
        c_is_write  = 1'b0;
        c_size      = '0;
        c_addr      = '0;
        c_strobe    = '0;
        c_data      = '0;
        c_len       = '0;
        resp_ready  = '0;
        resp_last   = '0;
        resp_data   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                c_valid             = 1'b1;
                c_is_write          = r_is_write;
                c_size              = r_size;
                c_addr              = r_addr;
                c_strobe            = r_strobe;
                c_len               = r_len;
                // Write data stays live so a burst can present a new word per beat.
                c_data              = w_data_a[r_owner];
                resp_ready[r_owner] = c_ready;
                resp_last[r_owner]  = c_ready & c_last;
                resp_data           = c_data_in;
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_is_write <= 1'b0;
            r_size     <= '0;
            r_addr     <= '0;
            r_strobe   <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_len_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && w_any) begin
                r_owner    <= w_win;
                r_grant    <= C_ONE << w_win;
                r_is_write <= w_wr_a[w_win];
                r_size     <= w_size_a[w_win];
                r_addr     <= w_addr_a[w_win];
                r_strobe   <= w_strobe_a[w_win];
                r_len      <= w_len_a[w_win];
                r_cnt      <= '0;
            end
            if (w_beat) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_done) begin
                // Counter holds beats already seen, so the last beat must match len.
                if (r_cnt != r_len) begin
                    r_len_err <= 1'b1;
                end
                r_grant <= '0;
                if (RR) begin
                    r_ptr <= (r_owner == IW'(NREQ-1)) ? '0 : r_owner + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbus_arbiter
// Description : Directed scoreboard bench for cbus_arbiter (fixed and RR policy).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbus_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_is_write;
    logic [5:0]    req_size;
    logic [127:0]  req_addr;
    logic [15:0]   req_strobe;
    logic [127:0]  req_data;
    logic [7:0]    req_len;
    logic          c_ready;
    logic          c_last;
    logic [63:0]   c_data_in;

    logic [1:0]    resp_ready, resp_last, grant;
    logic [63:0]   resp_data, c_addr, c_data;
    logic          c_valid, c_is_write, len_err;
    logic [2:0]    c_size;
    logic [7:0]    c_strobe;
    logic [3:0]    c_len;

    logic [1:0]    rr_resp_ready, rr_resp_last, rr_grant;
    logic [63:0]   rr_resp_data, rr_c_addr, rr_c_data;
    logic          rr_c_valid, rr_c_is_write, rr_len_err;
    logic [2:0]    rr_c_size;
    logic [7:0]    rr_c_strobe;
    logic [3:0]    rr_c_len;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0]  port;
        logic        last;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];

    logic [63:0] bdata  [4] = '{64'h11, 64'h22, 64'h33, 64'h44};
    logic [1:0]  rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    always #5 clk = ~clk;

    cbus_arbiter #(.NREQ(2), .RR(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_is_write(req_is_write), .req_size(req_size),
        .req_addr(req_addr), .req_strobe(req_strobe), .req_data(req_data), .req_len(req_len),
        .resp_ready(resp_ready), .resp_last(resp_last), .resp_data(resp_data),
        .c_valid(c_valid), .c_is_write(c_is_write), .c_size(c_size), .c_addr(c_addr),
        .c_strobe(c_strobe), .c_data(c_data), .c_len(c_len),
        .c_ready(c_ready), .c_last(c_last), .c_data_in(c_data_in),
        .grant(grant), .len_err(len_err)
    );

    cbus_arbiter #(.NREQ(2), .RR(1'b1)) dut_rr (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_is_write(req_is_write), .req_size(req_size),
        .req_addr(req_addr), .req_strobe(req_strobe), .req_data(req_data), .req_len(req_len),
        .resp_ready(rr_resp_ready), .resp_last(rr_resp_last), .resp_data(rr_resp_data),
        .c_valid(rr_c_valid), .c_is_write(rr_c_is_write), .c_size(rr_c_size), .c_addr(rr_c_addr),
        .c_strobe(rr_c_strobe), .c_data(rr_c_data), .c_len(rr_c_len),
        .c_ready(c_ready), .c_last(c_last), .c_data_in(c_data_in),
        .grant(rr_grant), .len_err(rr_len_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic wr, input logic [63:0] a, input logic [3:0] l);
        req_is_write[p]      = wr;
        req_size[p*3 +: 3]   = 3'd3;
        req_addr[p*64 +: 64] = a;
        req_strobe[p*8 +: 8] = 8'hFF;
        req_len[p*4 +: 4]    = l;
    endtask

    task automatic beat(input logic last, input logic [63:0] d, input logic [1:0] port);
        c_ready   = 1'b1;
        c_last    = last;
        c_data_in = d;
        sb.push_back('{port, last, d});
    endtask

    task automatic idle_bus();
        c_ready   = 1'b0;
        c_last    = 1'b0;
        c_data_in = '0;
    endtask

    // Response monitor for the fixed-priority instance.
    always @(negedge clk) begin
        if (resp_ready !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 64'(resp_ready), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_port", 64'(resp_ready), 64'(e.port));
                chk("resp_last", 64'(resp_last), 64'(e.last ? e.port : 2'b00));
                chk("resp_data", resp_data, e.data);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_is_write = '0;
        req_size     = '0;
        req_addr     = '0;
        req_strobe   = '0;
        req_data     = '0;
        req_len      = '0;
        idle_bus();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_grant",   64'(grant), 64'd0);
        chk("rst_c_valid", 64'(c_valid), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_resp",    64'(resp_ready), 64'd0);
        chk("rst_c_addr",  c_addr, 64'd0);

        // Single read from port 1, completes on third busy cycle
        set_req(1, 1'b0, 64'h8000_0000, 4'd0);
        req_valid = 2'b10;
        #1 chk("t1_no_early_valid", 64'(c_valid), 64'd0);
        tick();
        chk("t1_c_valid", 64'(c_valid), 64'd1);
        chk("t1_grant",   64'(grant), 64'(2'b10));
        chk("t1_c_addr",  c_addr, 64'h8000_0000);
        req_valid          = 2'b00;
        req_addr[127:64]   = 64'hDEAD_BEEF;
        tick();
        chk("t1_latched_addr", c_addr, 64'h8000_0000);
        chk("t1_still_busy",   64'(c_valid), 64'd1);
        tick();
        beat(1'b1, 64'hA5A5, 2'b10);
        #1 chk("t1_resp_ready", 64'(resp_ready), 64'(2'b10));
        chk("t1_resp_last", 64'(resp_last), 64'(2'b10));
        tick();
        idle_bus();
        chk("t1_grant_clr", 64'(grant), 64'd0);
        chk("t1_c_valid_clr", 64'(c_valid), 64'd0);
        chk("t1_len_err", 64'(len_err), 64'd0);

        // Stray c_ready while idle
        c_ready = 1'b1;
        c_last  = 1'b1;
        #1 chk("idle_resp_ready", 64'(resp_ready), 64'd0);
        tick();
        chk("idle_grant", 64'(grant), 64'd0);
        idle_bus();

        // Collision under fixed priority
        set_req(0, 1'b0, 64'h1000, 4'd0);
        set_req(1, 1'b0, 64'h2000, 4'd0);
        req_valid = 2'b11;
        tick();
        chk("t2_grant0", 64'(grant), 64'(2'b01));
        chk("t2_addr0",  c_addr, 64'h1000);
        beat(1'b1, 64'hD0, 2'b01);
        tick();
        idle_bus();
        req_valid = 2'b10;
        chk("t2_bubble_grant", 64'(grant), 64'd0);
        chk("t2_bubble_valid", 64'(c_valid), 64'd0);
        tick();
        chk("t2_grant1", 64'(grant), 64'(2'b10));
        chk("t2_addr1",  c_addr, 64'h2000);
        beat(1'b1, 64'hD1, 2'b10);
        tick();
        idle_bus();
        req_valid = 2'b00;
        chk("t2_grant_clr", 64'(grant), 64'd0);

        // Burst write with live data per beat
        set_req(0, 1'b1, 64'h3000, 4'd3);
        req_data[63:0] = bdata[0];
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("t4_grant",  64'(grant), 64'(2'b01));
        chk("t4_c_len",  64'(c_len), 64'd3);
        chk("t4_is_wr",  64'(c_is_write), 64'd1);
        chk("t4_strobe", 64'(c_strobe), 64'hFF);
        for (int b = 0; b < 4; b++) begin
            req_data[63:0] = bdata[b];
            beat(b == 3, 64'(64'h100 + b), 2'b01);
            #1 chk("t4_c_data", c_data, bdata[b]);
            tick();
        end
        idle_bus();
        chk("t4_grant_clr", 64'(grant), 64'd0);
        chk("t4_len_err",   64'(len_err), 64'd0);

        // Early c_last against len=3
        set_req(0, 1'b0, 64'h4000, 4'd3);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        beat(1'b0, 64'h50, 2'b01);
        tick();
        beat(1'b1, 64'h51, 2'b01);
        tick();
        idle_bus();
        chk("t5_grant_clr", 64'(grant), 64'd0);
        chk("t5_len_err",   64'(len_err), 64'd1);
        set_req(1, 1'b0, 64'h5000, 4'd0);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        beat(1'b1, 64'h60, 2'b10);
        tick();
        idle_bus();
        chk("t5_len_err_sticky", 64'(len_err), 64'd1);

        // Reset in the middle of a burst
        set_req(0, 1'b0, 64'h6000, 4'd3);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("t6_grant", 64'(grant), 64'(2'b01));
        beat(1'b0, 64'h70, 2'b01);
        tick();
        c_ready   = 1'b1;
        c_data_in = 64'h71;
        reset     = 1'b1;
        #1 chk("t6_c_valid_async", 64'(c_valid), 64'd0);
        chk("t6_grant_async", 64'(grant), 64'd0);
        chk("t6_resp_async",  64'(resp_ready), 64'd0);
        chk("t6_len_err_rst", 64'(len_err), 64'd0);
        idle_bus();
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 1'b0, 64'h1000, 4'd0);
        set_req(1, 1'b0, 64'h7000, 4'd0);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        chk("t6_regrant", 64'(grant), 64'(2'b10));
        chk("t6_addr",    c_addr, 64'h7000);
        beat(1'b1, 64'h80, 2'b10);
        tick();
        idle_bus();
        chk("t6_grant_clr", 64'(grant), 64'd0);

        // Continuous requests: round robin alternates, fixed priority starves port 1
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("t3_rr_grant",  64'(rr_grant), 64'(rr_exp[t]));
            chk("t3_fix_grant", 64'(grant), 64'(2'b01));
            beat(1'b1, 64'(64'h90 + t), 2'b01);
            #1 chk("t3_rr_resp", 64'(rr_resp_ready), 64'(rr_exp[t]));
            tick();
            idle_bus();
            chk("t3_rr_bubble", 64'(rr_grant), 64'd0);
            chk("t3_rr_cvalid", 64'(rr_c_valid), 64'd0);
        end
        req_valid = 2'b00;
        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares the single downstream memory bus (cbus) between NREQ upstream requesters: port 0 is the dbus path, port 1 is the ibus path from the core.
- Sits between the core's ibus/dbus request converters and the memory/uncached bridge.
- Grants one requester at a time and holds the grant until the final response beat.
- Latches the request fields at grant time, routes response beats back to the granted requester, and checks beat count against the requested length.

Parameters:
- NREQ, 2, number of requesters; index 0 has highest fixed priority.
- RR, 0, 1 selects round-robin arbitration; 0 selects fixed priority.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  request pending, per requester.
- req_is_write  in  NREQ  write request, per requester.
- req_size  in  3*NREQ  log2 bytes per beat, per requester.
- req_addr  in  64*NREQ  start address, per requester.
- req_strobe  in  8*NREQ  byte strobes, per requester.
- req_data  in  64*NREQ  write data, live, per requester.
- req_len  in  4*NREQ  beats minus one, per requester.
- resp_ready  out  NREQ  beat accepted/returned to that requester.
- resp_last  out  NREQ  final beat to that requester.
- resp_data  out  64  read data, shared; valid only with resp_ready[i].
- c_valid  out  1  downstream request valid.
- c_is_write, c_size[3], c_addr[64], c_strobe[8], c_data[64], c_len[4]  out  downstream request fields.
- c_ready  in  1  downstream beat handshake.
- c_last  in  1  downstream final beat.
- c_data_in  in  64  downstream read data.
- grant  out  NREQ  one-hot current owner; 0 when idle.
- len_err  out  1  sticky beat-count mismatch flag.

Behaviour:
- States:
  - IDLE: grant=0, c_valid=0.
  - BUSY: owner held.
- Reset:
  - state=IDLE, grant=0, c_valid=0, all resp_* =0, len_err=0, beat counter=0.
  - RR pointer=0, latched fields=0.
  - Reset asserted mid-transaction drops the transaction immediately; no response is delivered.
- IDLE -> BUSY, on any req_valid bit set at a clk edge:
  - Winner is the lowest index set when RR=0.
  - Winner is the first set index at or after the pointer, wrapping modulo NREQ, when RR=1.
  - Winner's is_write/size/addr/strobe/len are registered; grant=onehot(winner).
- Latency: c_valid rises the cycle after req_valid is first seen in IDLE (1 cycle).
- BUSY:
  - c_valid=1; c_* come from the latched fields.
  - c_data is forwarded combinationally from req_data[owner], so burst writes can update data per beat.
  - resp_ready[owner]=c_ready, resp_last[owner]=c_ready&c_last, resp_data=c_data_in.
  - Non-owner resp_* =0.
- Beat counter:
  - Increments on each c_ready while BUSY.
  - On c_ready&c_last, if counter != latched len, len_err is set (sticky until reset).
- BUSY -> IDLE on c_ready&c_last:
  - grant clears at that edge.
  - When RR=1, pointer = (owner+1) mod NREQ.
  - Re-arbitration occurs in the following IDLE cycle.
  - One idle bubble between back-to-back transactions is required; this guarantees deassertion of c_valid between transactions.
- Requester behaviour while BUSY:
  - A requester changing or dropping req_valid during its own grant does not change latched fields or terminate the transaction.
  - A non-owner asserting req_valid waits; its request is not sampled until IDLE.
- Simultaneous events:
  - A new req_valid in the same cycle as c_last is ignored until the IDLE cycle.
  - Multiple simultaneous requests are resolved per the policy above.
- Downstream rules:
  - c_ready while IDLE is ignored and is not routed to any requester.
  - c_last without c_ready is ignored.

Test Plan:
- Single read, port 1: req_valid=2'b10, addr=0x8000_0000, len=0, c_ready&c_last on the 3rd BUSY cycle -> c_valid one cycle after request, c_addr=0x8000_0000, resp_ready[1]=resp_last[1]=1 in that cycle, grant=2'b00 next cycle, len_err=0.
- Collision, RR=0: both valid in the same cycle -> port 0 granted first; port 1 granted in the IDLE cycle after port 0's last beat.
- Round-robin, RR=1: both valid continuously for 4 transactions -> grant sequence 01,10,01,10.
- Burst write, port 0: len=3, data 0x11/0x22/0x33/0x44 changed per beat -> c_data tracks each beat, c_len=3, 4 resp_ready pulses, last on the 4th, len_err=0.
- Length mismatch: len=3 but c_last on the 2nd beat -> transaction ends and len_err=1, which persists through subsequent correct transactions until reset.
- Reset mid-burst: reset asserted during BUSY beat 2 -> c_valid=0 and grant=0 asynchronously; after release, a new request from port 1 is granted normally.
